// File: rtl/ins_fetch.sv
// ins_fetch: instruction fetch/sequencing unit with operand fetch, jumps, immediates and halt
module ins_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [3:0]        ir,
  output logic [3:0]        operand,
  output logic              en,
  input  logic              jmp,
  input  logic              jg,
  input  logic              movi,
  input  logic              halt,
  input  logic              gflag,
  input  logic              exec_done,
  output logic [7:0]        imm,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_OPFETCH, S_OPWAIT, S_EXEC, S_HALT
  } state_t;
  typedef enum logic [1:0] {K_JMP, K_JG, K_MOVI} kind_t;
  state_t st, nxt;
  kind_t kind;
  // state register
  always_ff @(posedge clk)
    if (rst) st <= S_IDLE;
    else st <= nxt;
  // next-state: decoder lines only matter in DECODE, exec_done only in EXEC
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:    nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:   nxt = S_WAIT;
      S_WAIT:    nxt = S_DECODE;
      S_DECODE:  nxt = halt ? S_HALT : (jmp || jg || movi) ? S_OPFETCH : S_EXEC;
      S_OPFETCH: nxt = S_OPWAIT;
      S_OPWAIT:  nxt = S_EXEC;
      S_EXEC:    nxt = exec_done ? S_FETCH : S_EXEC;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_IDLE;
    endcase
  end
  // outputs decoded from the current state
  always_comb begin
    mem_rd = st == S_FETCH || st == S_OPFETCH;
    mem_addr = mem_rd ? pc : '0;
    en = st == S_DECODE || st == S_EXEC;
    running = st != S_IDLE && st != S_HALT;
    halted = st == S_HALT;
  end
  // instruction/operand capture, pc sequencing and immediate load
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      ir <= '0;
      operand <= '0;
      imm <= '0;
      imm_valid <= 1'b0;
      kind <= K_JMP;
    end else begin
      imm_valid <= st == S_OPWAIT && kind == K_MOVI;
      if (st == S_WAIT) begin
        ir <= mem_data[7:4];
        operand <= mem_data[3:0];
        pc <= pc + ADDR_W'(1);
      end
      if (st == S_DECODE) kind <= jmp ? K_JMP : jg ? K_JG : K_MOVI;
      if (st == S_OPWAIT) begin
        pc <= (kind == K_JMP || (kind == K_JG && gflag)) ? ADDR_W'(mem_data) : pc + ADDR_W'(1);
        if (kind == K_MOVI) imm <= mem_data;
      end
    end
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: directed and randomized checks of ins_fetch against an ISA-level program model
module tb_ins_fetch;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst = 1, start = 0, gflag = 0;
  logic [7:0] mem_addr, mem_data, imm, pc;
  logic [3:0] ir, operand;
  logic mem_rd, en, jmp, jg, movi, halt, exec_done, imm_valid, running, halted;
  logic ed_man = 1, ed_rand = 0, rnd_ed = 0, multi = 0;
  logic [7:0] rom [256];
  int total = 0, bad = 0, cyc = 0, en_cnt = 0;
  int rcyc[$];
  bq_t reads, imms, exp_reads, exp_imms, e;
  bit m_halt;
  logic [7:0] m_pc;

  ins_fetch #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .ir(ir), .operand(operand), .en(en), .jmp(jmp), .jg(jg),
    .movi(movi), .halt(halt), .gflag(gflag), .exec_done(exec_done), .imm(imm),
    .imm_valid(imm_valid), .pc(pc), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  assign jmp  = en && (multi || ir == 4'hA);
  assign jg   = en && (multi || ir == 4'hB);
  assign movi = en && (multi || ir == 4'h2);
  assign halt = en && (multi || ir == 4'h3);
  assign exec_done = rnd_ed ? ed_rand : ed_man;

  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  always @(negedge clk) begin
    cyc++;
    ed_rand = 1'($urandom_range(0, 1));
    if (!rst) begin
      if (mem_rd) begin reads.push_back(mem_addr); rcyc.push_back(cyc); end
      if (imm_valid) imms.push_back(imm);
      if (en) en_cnt++;
    end
  end

  function automatic bit q_pre(input bq_t a, input bq_t b);
    if (a.size() > b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  function automatic bit q_eq(input bq_t a, input bq_t b);
    return a.size() == b.size() && q_pre(a, b);
  endfunction

  function automatic string fmt(input bq_t q);
    string s = "";
    foreach (q[i]) if (i < 40) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_trace();
    reads = {}; imms = {}; rcyc = {}; en_cnt = 0;
  endtask

  task automatic clr_rom();
    foreach (rom[i]) rom[i] = 8'h30;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; tick(2); rst = 0; clear_trace();
  endtask

  task automatic wait_halt(input int budget, output bit to);
    to = 1;
    for (int i = 0; i < budget; i++) begin
      if (halted) begin to = 0; break; end
      tick();
    end
  endtask

  task automatic go(input int budget, output bit to);
    start = 1; tick(); start = 0;
    wait_halt(budget, to);
  endtask

  // ISA-level program interpreter: expected read addresses, immediates, final pc
  task automatic model_run(input bit g);
    logic [7:0] p, op;
    exp_reads = {}; exp_imms = {}; m_halt = 0; p = 0;
    for (int k = 0; k < 30 && !m_halt; k++) begin
      exp_reads.push_back(p); op = rom[p]; p = p + 8'd1;
      case (op[7:4])
        4'h3: m_halt = 1;
        4'hA: begin exp_reads.push_back(p); p = rom[p]; end
        4'hB: begin exp_reads.push_back(p); p = g ? rom[p] : p + 8'd1; end
        4'h2: begin exp_reads.push_back(p); exp_imms.push_back(rom[p]); p = p + 8'd1; end
        default: ;
      endcase
    end
    m_pc = p;
  endtask

  task automatic test_reset();
    rst = 1; start = 1; gflag = 1; ed_man = 1; tick(3);
    total++;
    if ({pc, ir, operand, imm, mem_addr, mem_rd, en, imm_valid, running, halted} !== '0) begin
      bad++; $display("FAIL reset_state: pc=%h ir=%h opnd=%h imm=%h addr=%h rd=%b en=%b iv=%b run=%b hlt=%b, want all 0",
        pc, ir, operand, imm, mem_addr, mem_rd, en, imm_valid, running, halted);
    end
    rst = 0; start = 0; gflag = 0; clear_trace(); tick(3);
    total++;
    if (running !== 0 || reads.size() != 0) begin
      bad++; $display("FAIL idle_hold: running=%b reads=%0d, want 0 0", running, reads.size());
    end
  endtask

  task automatic test_fetch_halt();
    bit to;
    clr_rom(); rom[0] = 8'h40; rom[1] = 8'h30;
    do_reset(); ed_man = 0; start = 1; tick(); start = 0;
    to = 1;
    for (int i = 0; i < 10; i++) begin
      if (en) begin to = 0; break; end
      tick();
    end
    total++;
    if (to || ir !== 4'h4) begin bad++; $display("FAIL decode_ir: ir=%h to=%b, want 4", ir, to); end
    tick(4);
    total++;
    if (en !== 1 || running !== 1) begin bad++; $display("FAIL stall_en: en=%b running=%b, want 1 1", en, running); end
    ed_man = 1;
    wait_halt(20, to);
    total++;
    if (to || ir !== 4'h3 || halted !== 1 || running !== 0) begin
      bad++; $display("FAIL halt_state: to=%b ir=%h halted=%b running=%b, want 0 3 1 0", to, ir, halted, running);
    end
    total++;
    if (pc !== 8'h02) begin bad++; $display("FAIL halt_pc: pc=%h, want 02", pc); end
    total++;
    if (en_cnt != 6) begin bad++; $display("FAIL en_cycles: got %0d, want 6", en_cnt); end
    start = 1; tick(2); start = 0; tick(5);
    e = '{8'h00, 8'h01};
    total++;
    if (!q_eq(reads, e) || mem_rd !== 0 || halted !== 1 || pc !== 8'h02) begin
      bad++; $display("FAIL halt_frozen: reads=[%s] rd=%b halted=%b pc=%h, want [00 01] 0 1 02", fmt(reads), mem_rd, halted, pc);
    end
  endtask

  task automatic test_jmp();
    bit to;
    clr_rom(); rom[0] = 8'hA0; rom[1] = 8'h05; rom[5] = 8'h30;
    do_reset(); ed_man = 1; go(60, to);
    e = '{8'h00, 8'h01, 8'h05};
    total++;
    if (to || !q_eq(reads, e)) begin bad++; $display("FAIL jmp_reads: got [%s] to=%b, want [%s]", fmt(reads), to, fmt(e)); end
    total++;
    if (pc !== 8'h06 || halted !== 1) begin bad++; $display("FAIL jmp_pc: pc=%h halted=%b, want 06 1", pc, halted); end
  endtask

  task automatic test_jg();
    bit to;
    for (int g = 0; g < 2; g++) begin
      clr_rom(); rom[0] = 8'hB0; rom[1] = 8'h07; rom[2] = 8'h30; rom[7] = 8'h30;
      gflag = 1'(g); do_reset(); ed_man = 1; go(60, to);
      if (g == 1) e = '{8'h00, 8'h01, 8'h07};
      else e = '{8'h00, 8'h01, 8'h02};
      total++;
      if (to || !q_eq(reads, e)) begin bad++; $display("FAIL jg%0d_reads: got [%s], want [%s]", g, fmt(reads), fmt(e)); end
      total++;
      if (pc !== (g == 1 ? 8'h08 : 8'h03)) begin bad++; $display("FAIL jg%0d_pc: pc=%h, want %h", g, pc, g == 1 ? 8'h08 : 8'h03); end
      total++;
      if (rcyc.size() < 3 || rcyc[1] - rcyc[0] != 3 || rcyc[2] - rcyc[0] != 6) begin
        bad++; $display("FAIL jg%0d_timing: %0d reads, want op read +3 and next fetch +6", g, rcyc.size());
      end
    end
    gflag = 0;
  endtask

  task automatic test_movi();
    bit to;
    clr_rom(); rom[0] = 8'h20; rom[1] = 8'h5A; rom[2] = 8'h30;
    do_reset(); ed_man = 1; go(60, to);
    e = '{8'h5A};
    total++;
    if (to || !q_eq(imms, e) || imm !== 8'h5A) begin
      bad++; $display("FAIL movi_imm: pulses=[%s] imm=%h, want one pulse with 5a", fmt(imms), imm);
    end
    e = '{8'h00, 8'h01, 8'h02};
    total++;
    if (!q_eq(reads, e) || rcyc[2] - rcyc[0] != 6) begin
      bad++; $display("FAIL movi_seq: reads=[%s], want [00 01 02] with 6-cycle spacing", fmt(reads));
    end
  endtask

  task automatic test_wrap();
    bit to;
    clr_rom(); rom[0] = 8'hA0; rom[1] = 8'hFF; rom[8'hFF] = 8'h80;
    do_reset(); ed_man = 1; start = 1; tick(); start = 0;
    to = 1;
    for (int i = 0; i < 80; i++) begin
      if (reads.size() >= 6) begin to = 0; break; end
      tick();
    end
    e = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01, 8'hFF};
    total++;
    if (to || !q_eq(reads, e)) begin bad++; $display("FAIL wrap_reads: got [%s], want [%s]", fmt(reads), fmt(e)); end
    total++;
    if (rcyc.size() < 4 || rcyc[3] - rcyc[2] != 4) begin bad++; $display("FAIL wrap_timing: plain instruction not 4 cycles"); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clr_rom(); rom[0] = 8'hA0; rom[1] = 8'h05; rom[5] = 8'h30;
    do_reset(); ed_man = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 20 && reads.size() < 2; i++) tick();
    tick();
    rst = 1; start = 1; tick();
    total++;
    if (pc !== 8'h00 || en !== 0 || mem_rd !== 0 || imm_valid !== 0 || running !== 0) begin
      bad++; $display("FAIL mid_reset: pc=%h en=%b rd=%b iv=%b run=%b, want 00 0 0 0 0", pc, en, mem_rd, imm_valid, running);
    end
    tick(2);
    total++;
    if (running !== 0 || halted !== 0) begin bad++; $display("FAIL rst_start: running=%b halted=%b, want 0 0", running, halted); end
    rst = 0; start = 0; clear_trace(); tick(2);
    go(60, to);
    e = '{8'h00, 8'h01, 8'h05};
    total++;
    if (to || !q_eq(reads, e) || pc !== 8'h06) begin
      bad++; $display("FAIL restart: reads=[%s] pc=%h, want [00 01 05] 06", fmt(reads), pc);
    end
  endtask

  task automatic test_priority();
    bit to;
    clr_rom(); rom[0] = 8'h40;
    multi = 1; do_reset(); ed_man = 1; go(30, to); multi = 0;
    e = '{8'h00};
    total++;
    if (to || !q_eq(reads, e) || pc !== 8'h01) begin
      bad++; $display("FAIL halt_priority: reads=[%s] pc=%h halted=%b, want [00] 01 1", fmt(reads), pc, halted);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [7];
    bit g, to;
    ops = '{4'h0, 4'h4, 4'h8, 4'h3, 4'hA, 4'hB, 4'h2};
    for (int it = 0; it < 25; it++) begin
      foreach (rom[i]) rom[i] = {ops[$urandom_range(0, 6)], 4'($urandom)};
      g = 1'($urandom); gflag = g;
      model_run(g);
      do_reset(); rnd_ed = 1; start = 1; tick(); start = 0;
      to = 1;
      for (int i = 0; i < 2000; i++) begin
        if (halted || (!m_halt && reads.size() >= exp_reads.size())) begin to = 0; break; end
        start = 1'($urandom);
        tick();
      end
      start = 0; rnd_ed = 0;
      total++;
      if (to || !q_eq(reads, exp_reads) || halted !== m_halt) begin
        bad++; $display("FAIL rand%0d_reads: got [%s] halted=%b, want [%s] halted=%b", it, fmt(reads), halted, fmt(exp_reads), m_halt);
      end
      total++;
      if (m_halt ? !q_eq(imms, exp_imms) : !q_pre(imms, exp_imms)) begin
        bad++; $display("FAIL rand%0d_imm: got [%s], want [%s]", it, fmt(imms), fmt(exp_imms));
      end
      if (m_halt) begin
        total++;
        if (pc !== m_pc || ir !== 4'h3) begin bad++; $display("FAIL rand%0d_pc: pc=%h ir=%h, want %h 3", it, pc, ir, m_pc); end
      end
    end
    gflag = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_halt();
    test_jmp();
    test_jg();
    test_movi();
    test_wrap();
    test_reset_mid();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
